sram_1p_masked_array: RTL and testbench

Parametrised single-port masked SRAM model: the next generation of the generated fixed-geometry array wrappers. Adds:
- configurable depth, width and mask granularity;
- a self-clearing init sequencer after reset;
- a registered read output with selectable latency that holds its value;
- a read-valid strobe and an out-of-range error strobe.

It sits under the cache/TLB array wrappers as a drop-in behavioural memory for simulation and FPGA builds.

---
 rtl/sram_1p_masked_array.sv | 129 ++++++++++++
 tb/tb_sram_1p_masked_array.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1p_masked_array.sv
// Single-port masked SRAM with a post-reset clear sequencer and a 1- or 2-cycle registered read.
// Read data holds between reads; rvalid and err are single-cycle strobes.
//
// state   | meaning
// ST_INIT | writing INIT_VALUE to entry init_cnt (passes straight to ST_RUN when INIT_ON_RESET=0)
// ST_RUN  | ready, accepting read/write requests
module sram_1p_masked_array #(
  parameter int DEPTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 90,
  parameter int MASK_WIDTH = 2,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  RW0_en,
  input  logic                  RW0_wmode,
  input  logic [ADDR_WIDTH-1:0] RW0_addr,
  input  logic [MASK_WIDTH-1:0] RW0_wmask,
  input  logic [DATA_WIDTH-1:0] RW0_wdata,
  output logic [DATA_WIDTH-1:0] RW0_rdata,
  output logic                  RW0_rvalid,
  output logic                  RW0_ready,
  output logic                  RW0_err
);

  localparam int LW = DATA_WIDTH / MASK_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_n;
  logic                  init_we;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range, acc, rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  out_v;
  logic [DATA_WIDTH-1:0] out_d;

  assign RW0_ready = (state == ST_RUN);
  assign in_range  = ({1'b0, RW0_addr} < DEPTH_W);
  assign acc       = RW0_en && RW0_ready;
  assign rd_acc    = acc && !RW0_wmode;
  assign wr_acc    = acc && RW0_wmode && in_range;
  assign rd_word   = in_range ? mem[RW0_addr] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_n;
      init_cnt <= init_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    init_we    = 1'b0;
    case (state)
      ST_INIT: begin
        if (INIT_ON_RESET == 0) begin
          state_n = ST_RUN;
        end else begin
          init_we = !reset;
          if (init_cnt == LAST) begin
            state_n    = ST_RUN;
            init_cnt_n = '0;
          end else begin
            init_cnt_n = init_cnt + 1'b1;
          end
        end
      end
      ST_RUN:  state_n = ST_RUN;
      default: state_n = ST_INIT;
    endcase
  end

  // Storage is never reset; the sequencer is the only way contents get cleared.
  always_ff @(posedge clock) begin
    if (init_we) begin
      mem[init_cnt] <= INIT_VALUE;
    end else if (wr_acc) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (RW0_wmask[i]) mem[RW0_addr][i*LW +: LW] <= RW0_wdata[i*LW +: LW];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s1_v;
      logic [DATA_WIDTH-1:0] s1_d;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          s1_v <= 1'b0;
          s1_d <= '0;
        end else begin
          s1_v <= rd_acc;
          if (rd_acc) s1_d <= rd_word;
        end
      end
      assign out_v = s1_v;
      assign out_d = s1_d;
    end else begin : g_lat1
      assign out_v = rd_acc;
      assign out_d = rd_word;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      RW0_rdata  <= '0;
      RW0_rvalid <= 1'b0;
      RW0_err    <= 1'b0;
    end else begin
      RW0_rvalid <= out_v;
      RW0_err    <= acc && !in_range;
      if (out_v) RW0_rdata <= out_d;
    end
  end

endmodule

// File: tb/tb_sram_1p_masked_array.sv
// Drives four differently configured arrays with one shared stimulus stream and checks every
// output each cycle against an edge-counting behavioural model, plus hand-computed literals.
module tb_sram_1p_masked_array;

  localparam int AW = 5;
  localparam int DW = 90;
  localparam int MW = 2;
  localparam int LW = 45;
  localparam int NI = 4;
  localparam logic [DW-1:0] IV = 90'h5A;
  localparam int DEP [NI] = '{32, 32, 20, 20};
  localparam int LAT [NI] = '{1, 2, 1, 2};
  localparam int INI [NI] = '{1, 1, 1, 0};

  logic          clock;
  logic          reset;
  logic          RW0_en, RW0_wmode;
  logic [AW-1:0] RW0_addr;
  logic [MW-1:0] RW0_wmask;
  logic [DW-1:0] RW0_wdata;
  logic [DW-1:0] rd [NI];
  logic          rv [NI];
  logic          rdy [NI];
  logic          er [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_1p_masked_array #(
      .DEPTH(DEP[g]), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
      .READ_LATENCY(LAT[g]), .INIT_ON_RESET(INI[g]), .INIT_VALUE(IV)
    ) u_dut (
      .clock(clock), .reset(reset), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
      .RW0_addr(RW0_addr), .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata),
      .RW0_rdata(rd[g]), .RW0_rvalid(rv[g]), .RW0_ready(rdy[g]), .RW0_err(er[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: contents plus a per-bit "known" mask (entries never written are don't-care).
  logic [DW-1:0] mm [NI][32];
  logic [DW-1:0] mk [NI][32];
  int            ep [NI];
  logic          hv [NI][2];
  logic [DW-1:0] hd [NI][2];
  logic [DW-1:0] hk [NI][2];
  logic [DW-1:0] e_rd [NI];
  logic [DW-1:0] e_k [NI];
  logic          e_rv [NI], e_er [NI], e_rdy [NI];
  logic          m_rdy, m_acc, m_inr;

  initial begin
    for (int i = 0; i < NI; i++)
      for (int a = 0; a < 32; a++) begin
        mm[i][a] = '0;
        mk[i][a] = '0;
      end
  end

  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        ep[i] = 0;
        hv[i][0] = 1'b0; hv[i][1] = 1'b0;
        hd[i][0] = '0;   hd[i][1] = '0;
        hk[i][0] = '1;   hk[i][1] = '1;
        e_rd[i] = '0; e_k[i] = '1; e_rv[i] = 1'b0; e_er[i] = 1'b0; e_rdy[i] = 1'b0;
      end else begin
        m_rdy = (ep[i] >= ((INI[i] != 0) ? DEP[i] : 1));
        if (INI[i] != 0 && ep[i] < DEP[i]) begin
          mm[i][ep[i]] = IV;
          mk[i][ep[i]] = '1;
        end
        if (ep[i] < 1000) ep[i]++;
        e_rdy[i] = (ep[i] >= ((INI[i] != 0) ? DEP[i] : 1));
        m_acc = RW0_en && m_rdy;
        m_inr = int'(RW0_addr) < DEP[i];
        e_er[i] = m_acc && !m_inr;
        if (m_acc && RW0_wmode && m_inr)
          for (int l = 0; l < MW; l++)
            if (RW0_wmask[l]) begin
              mm[i][RW0_addr][l*LW +: LW] = RW0_wdata[l*LW +: LW];
              mk[i][RW0_addr][l*LW +: LW] = '1;
            end
        hv[i][1] = hv[i][0]; hd[i][1] = hd[i][0]; hk[i][1] = hk[i][0];
        hv[i][0] = m_acc && !RW0_wmode;
        hd[i][0] = m_inr ? mm[i][RW0_addr] : '0;
        hk[i][0] = m_inr ? mk[i][RW0_addr] : '1;
        e_rv[i] = hv[i][LAT[i]-1];
        if (e_rv[i]) begin
          e_rd[i] = hd[i][LAT[i]-1];
          e_k[i]  = hk[i][LAT[i]-1];
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("ready[%0d]", i), DW'(rdy[i]), DW'(e_rdy[i]));
      chk($sformatf("rvalid[%0d]", i), DW'(rv[i]), DW'(e_rv[i]));
      chk($sformatf("err[%0d]", i), DW'(er[i]), DW'(e_er[i]));
      chk($sformatf("rdata[%0d]", i), rd[i] & e_k[i], e_rd[i] & e_k[i]);
    end
  end

  task automatic cyc(input logic e, input logic w, input int a, input logic [MW-1:0] m,
                     input logic [DW-1:0] d);
    @(negedge clock);
    RW0_en = e; RW0_wmode = w; RW0_addr = AW'(a); RW0_wmask = m; RW0_wdata = d;
  endtask

  task automatic after_edge;
    @(posedge clock);
    #1;
  endtask

  task automatic count_init(input string nm, input int exp_cyc, input logic poke);
    int c = 0;
    while (!rdy[0] && c < 100) begin
      if (poke) begin
        RW0_en = 1'b1; RW0_wmode = 1'($urandom_range(0, 1));
        RW0_addr = AW'($urandom_range(0, 31)); RW0_wmask = '1;
        RW0_wdata = DW'({$urandom, $urandom, $urandom});
      end
      @(posedge clock);
      #1;
      c++;
    end
    RW0_en = 1'b0;
    chk(nm, DW'(c), DW'(exp_cyc));
  endtask

  task automatic sweep;
    for (int a = 0; a < 32; a++) cyc(1'b1, 1'b0, a, '0, '0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 0, '0, '0);
  endtask

  logic [DW-1:0] d1, d2, d3, d4, d5, d6;

  initial begin
    d1 = {3{30'h1234_5678}};
    d2 = {3{30'h2BAD_BEEF}};
    d3 = {3{30'h0F0F_0F0F}};
    d4 = {3{30'h3C3C_A5A5}};
    d5 = {3{30'h0765_4321}};
    d6 = {3{30'h1357_9BDF}};
    reset = 1'b1;
    RW0_en = 1'b0; RW0_wmode = 1'b0; RW0_addr = '0; RW0_wmask = '0; RW0_wdata = '0;
    repeat (3) @(negedge clock);
    chk("reset_ready", DW'(rdy[0]), DW'(0));
    chk("reset_rdata", rd[0], '0);
    #2 reset = 1'b0;
    count_init("init_len", 32, 1'b0);

    // Read of the last entry right after init
    cyc(1'b1, 1'b0, 31, '0, '0);
    after_edge;
    chk("t1_rdata", rd[0], 90'h5A);
    chk("t1_rvalid", DW'(rv[0]), DW'(1));
    cyc(1'b0, 1'b0, 0, '0, '0);
    after_edge;
    chk("t1_rvalid_drop", DW'(rv[0]), DW'(0));

    // Lane-masked write
    cyc(1'b1, 1'b1, 3, 2'b01, '1);
    cyc(1'b1, 1'b0, 3, '0, '0);
    after_edge;
    chk("t2_lane", rd[0], {45'h0, {45{1'b1}}});

    // Back-to-back reads through the two-stage instance
    cyc(1'b1, 1'b1, 1, 2'b11, d1);
    cyc(1'b1, 1'b1, 2, 2'b11, d2);
    cyc(1'b1, 1'b1, 3, 2'b11, d3);
    cyc(1'b1, 1'b0, 1, '0, '0);
    cyc(1'b1, 1'b0, 2, '0, '0);
    after_edge;
    chk("t3_lat2_d1", rd[1], d1);
    chk("t3_lat2_v1", DW'(rv[1]), DW'(1));
    cyc(1'b1, 1'b0, 3, '0, '0);
    after_edge;
    chk("t3_lat2_d2", rd[1], d2);
    cyc(1'b0, 1'b0, 0, '0, '0);
    after_edge;
    chk("t3_lat2_d3", rd[1], d3);
    chk("t3_lat2_v3", DW'(rv[1]), DW'(1));
    cyc(1'b0, 1'b0, 0, '0, '0);
    after_edge;
    chk("t3_lat2_vdrop", DW'(rv[1]), DW'(0));
    chk("t3_lat2_hold", rd[1], d3);

    // Hold across a later write, then re-read
    cyc(1'b1, 1'b0, 4, '0, '0);
    cyc(1'b1, 1'b1, 4, 2'b11, d4);
    after_edge;
    chk("t4_hold_w", rd[0], 90'h5A);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 0, '0, '0);
      after_edge;
      chk("t4_hold", rd[0], 90'h5A);
    end
    cyc(1'b1, 1'b0, 4, '0, '0);
    after_edge;
    chk("t4_reread", rd[0], d4);
    cyc(1'b1, 1'b1, 5, 2'b11, d5);
    cyc(1'b1, 1'b0, 5, '0, '0);
    after_edge;
    chk("t4_wr_then_rd", rd[0], d5);

    // Out-of-range on the 20-entry instance
    cyc(1'b1, 1'b1, 25, 2'b11, d6);
    after_edge;
    chk("t5_err_wr", DW'(er[2]), DW'(1));
    cyc(1'b1, 1'b0, 25, '0, '0);
    after_edge;
    chk("t5_err_rd", DW'(er[2]), DW'(1));
    chk("t5_rd_zero", rd[2], '0);
    chk("t5_rv", DW'(rv[2]), DW'(1));
    chk("t5_inrange_32", rd[0], d6);
    cyc(1'b0, 1'b0, 0, '0, '0);
    after_edge;
    chk("t5_err_drop", DW'(er[2]), DW'(0));
    sweep;

    // Reset during init, then a full re-init with requests poked while not ready
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_rdata", rd[0], '0);
    chk("t6_rst_rvalid", DW'(rv[0]), DW'(0));
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (10) after_edge;
    #2 reset = 1'b1;
    #1;
    chk("t6_mid_ready", DW'(rdy[0]), DW'(0));
    chk("t6_mid_rdata", rd[0], '0);
    @(negedge clock);
    #2 reset = 1'b0;
    count_init("t6_init_len", 32, 1'b1);
    sweep;

    // Random traffic with one reset in the middle
    for (int k = 0; k < 600; k++) begin
      if (k == 300) begin
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
        count_init("rand_init_len", 32, 1'b0);
      end
      cyc(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
          MW'($urandom_range(0, 3)), DW'({$urandom, $urandom, $urandom}));
    end
    sweep;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

endmodule
